// File: rtl/pc_pkg.sv
// Shared encodings for the PC redirect register: FSM states, redirect kinds, default vectors.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_t;

  typedef enum logic [1:0] {
    RK_NONE = 2'd0,
    RK_BR   = 2'd1,
    RK_JMP  = 2'd2,
    RK_EXC  = 2'd3
  } redir_kind_t;

  localparam int          DEF_WIDTH        = 32;
  localparam int          DEF_STEP         = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0040_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0040_0004;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending-redirect buffer holding a {kind, target} pair captured while stalled.
// Latency: written on the edge of the request, readable the following cycle.
// Backpressure: none; a newer write overwrites unless a held EXC would be displaced by a non-EXC.
// Ports: i_clk/i_rst (sync, active-high), i_clr empties, i_wr_vld/i_wr_kind/i_wr_tgt write,
//        o_vld/o_kind/o_tgt expose the held entry.
module pc_redirect_buf
  import pc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_wr_vld,
  input  logic [1:0]       i_wr_kind,
  input  logic [WIDTH-1:0] i_wr_tgt,
  output logic             o_vld,
  output logic [1:0]       o_kind,
  output logic [WIDTH-1:0] o_tgt
);

  logic             r_vld;
  redir_kind_t      r_kind;
  logic [WIDTH-1:0] r_tgt;
  logic             w_accept;

  // A held exception is sticky against anything weaker than another exception.
  assign w_accept = !(r_vld && (r_kind == RK_EXC) && (i_wr_kind != RK_EXC));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld  <= 1'b0;
      r_kind <= RK_NONE;
      r_tgt  <= '0;
    end else if (i_clr) begin
      r_vld  <= 1'b0;
      r_kind <= RK_NONE;
    end else if (i_wr_vld && w_accept) begin
      r_vld  <= 1'b1;
      r_kind <= redir_kind_t'(i_wr_kind);
      r_tgt  <= i_wr_tgt;
    end
  end

  assign o_vld  = r_vld;
  assign o_kind = r_kind;
  assign o_tgt  = r_tgt;

endmodule

// File: rtl/pc_redirect_reg.sv
// Program counter with prioritised redirects (EXC > JMP > BR > +STEP), stall buffering and BOOT/RUN/HALT gating.
// Latency: one cycle from redirect request to PC; a buffered redirect lands one cycle after the first EN=1 cycle.
// Backpressure: EN=0 stalls the PC; one non-exception redirect is held until EN returns; EXC is never stalled.
// Ports: CLK/RST (sync, active-high); EN stall control; BR_*/JMP_* redirect requests; EXC_VALID exception;
//        HALT_REQ/RESUME halt control; PC, PC_PLUS (comb), EPC, FETCH_VALID, MISALIGN, STATE outputs.
module pc_redirect_reg
  import pc_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter int               STEP         = DEF_STEP,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             BR_VALID,
  input  logic [WIDTH-1:0] BR_TARGET,
  input  logic             JMP_VALID,
  input  logic [WIDTH-1:0] JMP_TARGET,
  input  logic             EXC_VALID,
  input  logic             HALT_REQ,
  input  logic             RESUME,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_PLUS,
  output logic [WIDTH-1:0] EPC,
  output logic             FETCH_VALID,
  output logic             MISALIGN,
  output logic [1:0]       STATE
);

  pc_state_t        r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic             r_fetch_vld;
  logic             r_misalign;

  logic             w_run_free;
  logic [1:0]       w_live_kind;
  logic [WIDTH-1:0] w_live_tgt;
  logic             w_buf_wr;
  logic             w_buf_clr;
  logic             w_apply_buf;
  logic             w_apply_tgt;
  logic [WIDTH-1:0] w_tgt_raw;
  logic [WIDTH-1:0] w_pc_plus;
  logic             w_buf_vld;
  logic [1:0]       w_buf_kind;
  logic [WIDTH-1:0] w_buf_tgt;

  always_comb begin
    w_pc_plus   = r_pc + WIDTH'(STEP);
    // RUN with neither an exception nor a halt request: the only case where BR/JMP matter.
    w_run_free  = (r_state == ST_RUN) && !EXC_VALID && !HALT_REQ;
    w_live_kind = JMP_VALID ? RK_JMP : (BR_VALID ? RK_BR : RK_NONE);
    w_live_tgt  = JMP_VALID ? JMP_TARGET : BR_TARGET;
    w_buf_wr    = w_run_free && !EN && (w_live_kind != RK_NONE);
    // The held redirect takes precedence over live BR/JMP on the first enabled cycle.
    w_apply_buf = w_run_free && EN && w_buf_vld && (w_buf_kind != RK_NONE);
    w_apply_tgt = w_apply_buf || (w_run_free && EN && (w_live_kind != RK_NONE));
    w_tgt_raw   = w_apply_buf ? w_buf_tgt : w_live_tgt;
    w_buf_clr   = w_apply_buf || (EXC_VALID && (r_state != ST_BOOT));
  end

  pc_redirect_buf #(.WIDTH(WIDTH)) u_buf (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_clr     (w_buf_clr),
    .i_wr_vld  (w_buf_wr),
    .i_wr_kind (w_live_kind),
    .i_wr_tgt  (w_live_tgt),
    .o_vld     (w_buf_vld),
    .o_kind    (w_buf_kind),
    .o_tgt     (w_buf_tgt)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_VECTOR;
      r_epc       <= '0;
      r_fetch_vld <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      case (r_state)
        ST_BOOT: begin
          r_state     <= ST_RUN;
          r_fetch_vld <= 1'b1;
        end
        ST_RUN: begin
          if (EXC_VALID) begin
            r_pc  <= EXC_VECTOR;
            r_epc <= r_pc;
          end else if (HALT_REQ) begin
            r_state     <= ST_HALT;
            r_fetch_vld <= 1'b0;
          end else if (EN) begin
            if (w_apply_tgt) begin
              r_pc       <= {w_tgt_raw[WIDTH-1:2], 2'b00};
              r_misalign <= |w_tgt_raw[1:0];
            end else begin
              r_pc <= w_pc_plus;
            end
          end
        end
        ST_HALT: begin
          if (EXC_VALID) begin
            r_state     <= ST_RUN;
            r_fetch_vld <= 1'b1;
            r_pc        <= EXC_VECTOR;
            r_epc       <= r_pc;
          end else if (RESUME) begin
            r_state     <= ST_RUN;
            r_fetch_vld <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_BOOT;
          r_fetch_vld <= 1'b0;
        end
      endcase
    end
  end

  assign PC          = r_pc;
  assign PC_PLUS     = w_pc_plus;
  assign EPC         = r_epc;
  assign FETCH_VALID = r_fetch_vld;
  assign MISALIGN    = r_misalign;
  assign STATE       = r_state;

endmodule

// File: tb/tb_pc_redirect_reg.sv
// Self-checking bench for pc_redirect_reg: directed scenarios followed by random stimulus.
// Latency: every edge is compared against a behavioural model one time unit after the edge.
// Backpressure: EN is randomly dropped to exercise the pending-redirect buffer.
module tb_pc_redirect_reg;

  localparam logic [31:0] RV = 32'h0040_0000;
  localparam logic [31:0] EV = 32'h0040_0004;

  logic        CLK = 1'b0;
  logic        RST, EN, BR_VALID, JMP_VALID, EXC_VALID, HALT_REQ, RESUME;
  logic [31:0] BR_TARGET, JMP_TARGET;
  logic [31:0] PC, PC_PLUS, EPC;
  logic        FETCH_VALID, MISALIGN;
  logic [1:0]  STATE;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model: state as 0=BOOT 1=RUN 2=HALT.
  int          m_state = 0;
  logic [31:0] m_pc    = RV;
  logic [31:0] m_epc   = '0;
  bit          m_mis   = 1'b0;
  bit          m_pend  = 1'b0;
  logic [31:0] m_pt    = '0;
  logic [31:0] frozen;
  bit          saw_lost_br;

  pc_redirect_reg dut (
    .CLK         (CLK),
    .RST         (RST),
    .EN          (EN),
    .BR_VALID    (BR_VALID),
    .BR_TARGET   (BR_TARGET),
    .JMP_VALID   (JMP_VALID),
    .JMP_TARGET  (JMP_TARGET),
    .EXC_VALID   (EXC_VALID),
    .HALT_REQ    (HALT_REQ),
    .RESUME      (RESUME),
    .PC          (PC),
    .PC_PLUS     (PC_PLUS),
    .EPC         (EPC),
    .FETCH_VALID (FETCH_VALID),
    .MISALIGN    (MISALIGN),
    .STATE       (STATE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic take_target(input logic [31:0] t);
    m_pc  = t & 32'hFFFF_FFFC;
    m_mis = (t[1:0] != 2'b00);
  endtask

  task automatic take_exception();
    m_epc  = m_pc;
    m_pc   = EV;
    m_pend = 1'b0;
  endtask

  // Apply the specification's rules for one rising edge using the current inputs.
  task automatic model_edge();
    if (RST) begin
      m_state = 0; m_pc = RV; m_epc = '0; m_mis = 1'b0; m_pend = 1'b0;
      return;
    end
    m_mis = 1'b0;
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (EXC_VALID)      take_exception();
      else if (HALT_REQ)  m_state = 2;
      else if (!EN) begin
        if (JMP_VALID)     begin m_pend = 1'b1; m_pt = JMP_TARGET; end
        else if (BR_VALID) begin m_pend = 1'b1; m_pt = BR_TARGET;  end
      end else if (m_pend) begin
        take_target(m_pt);
        m_pend = 1'b0;
      end else if (JMP_VALID) take_target(JMP_TARGET);
      else if (BR_VALID)      take_target(BR_TARGET);
      else                    m_pc = m_pc + 32'd4;
    end else begin
      if (EXC_VALID) begin
        take_exception();
        m_state = 1;
      end else if (RESUME) m_state = 1;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    chk("pc",          PC,                  m_pc);
    chk("pc_plus",     PC_PLUS,             m_pc + 32'd4);
    chk("epc",         EPC,                 m_epc);
    chk("state",       {30'd0, STATE},      32'(m_state));
    chk("fetch_valid", {31'd0, FETCH_VALID}, {31'd0, (m_state == 1)});
    chk("misalign",    {31'd0, MISALIGN},   {31'd0, m_mis});
  endtask

  task automatic idle();
    EN = 1'b1; BR_VALID = 1'b0; JMP_VALID = 1'b0; EXC_VALID = 1'b0;
    HALT_REQ = 1'b0; RESUME = 1'b0; BR_TARGET = '0; JMP_TARGET = '0;
  endtask

  initial begin
    idle();
    RST = 1'b1;
    #2;
    // Reset and boot
    tick(); tick();
    chk("rst_pc", PC, RV);
    chk("rst_state", {30'd0, STATE}, 32'd0);
    chk("rst_fetch", {31'd0, FETCH_VALID}, 32'd0);
    chk("rst_epc", EPC, 32'd0);
    RST = 1'b0;
    tick();
    chk("boot_pc_hold", PC, RV);
    chk("boot_fetch_rise", {31'd0, FETCH_VALID}, 32'd1);
    tick(); chk("step1", PC, 32'h0040_0004);
    tick(); chk("step2", PC, 32'h0040_0008);
    tick(); tick();
    chk("at_10", PC, 32'h0040_0010);

    // Priority: exception beats jump and branch
    BR_VALID = 1'b1; BR_TARGET = 32'h0040_0300;
    JMP_VALID = 1'b1; JMP_TARGET = 32'h0040_0400;
    EXC_VALID = 1'b1;
    tick();
    chk("prio_pc", PC, EV);
    chk("prio_epc", EPC, 32'h0040_0010);
    idle();
    tick(); chk("prio_next", PC, 32'h0040_0008);

    // Stall buffering: later jump replaces earlier branch
    saw_lost_br = 1'b0;
    EN = 1'b0; BR_VALID = 1'b1; BR_TARGET = 32'h0040_0100;
    tick(); if (PC == 32'h0040_0100) saw_lost_br = 1'b1;
    chk("stall_hold", PC, 32'h0040_0008);
    BR_VALID = 1'b0; JMP_VALID = 1'b1; JMP_TARGET = 32'h0040_0200;
    tick(); if (PC == 32'h0040_0100) saw_lost_br = 1'b1;
    idle();
    tick(); if (PC == 32'h0040_0100) saw_lost_br = 1'b1;
    chk("buf_apply", PC, 32'h0040_0200);
    tick(); if (PC == 32'h0040_0100) saw_lost_br = 1'b1;
    chk("br_lost", {31'd0, saw_lost_br}, 32'd0);

    // Misalignment
    JMP_VALID = 1'b1; JMP_TARGET = 32'h0040_0203;
    tick();
    chk("mis_pc", PC, 32'h0040_0200);
    chk("mis_pulse", {31'd0, MISALIGN}, 32'd1);
    idle();
    tick();
    chk("mis_clear", {31'd0, MISALIGN}, 32'd0);

    // Wrap
    JMP_VALID = 1'b1; JMP_TARGET = 32'hFFFF_FFFC;
    tick();
    chk("wrap_plus", PC_PLUS, 32'd0);
    idle();
    tick();
    chk("wrap_pc", PC, 32'd0);
    chk("wrap_noflag", {31'd0, MISALIGN}, 32'd0);

    // Halt / resume
    HALT_REQ = 1'b1; BR_VALID = 1'b1; BR_TARGET = 32'h0000_0800;
    tick();
    idle();
    frozen = PC;
    chk("halt_state", {30'd0, STATE}, 32'd2);
    chk("halt_fetch", {31'd0, FETCH_VALID}, 32'd0);
    chk("halt_drop_br", frozen, 32'd0);
    for (int i = 0; i < 5; i++) begin
      BR_VALID = 1'b1; BR_TARGET = 32'h0000_0900;
      tick();
      chk("halt_frozen", PC, frozen);
    end
    idle(); RESUME = 1'b1;
    tick();
    chk("resume_state", {30'd0, STATE}, 32'd1);
    chk("resume_pc", PC, frozen);
    idle();
    tick(); chk("resume_step", PC, frozen + 32'd4);

    // Exception while halted
    HALT_REQ = 1'b1; tick(); idle();
    EXC_VALID = 1'b1; tick(); idle();
    chk("halt_exc_pc", PC, EV);
    chk("halt_exc_state", {30'd0, STATE}, 32'd1);

    // Reset while halted
    HALT_REQ = 1'b1; tick(); idle();
    RST = 1'b1; tick();
    chk("halt_rst_state", {30'd0, STATE}, 32'd0);
    chk("halt_rst_pc", PC, RV);
    RST = 1'b0;

    // Random stimulus
    for (int i = 0; i < 800; i++) begin
      RST        = ($urandom_range(0, 149) == 0);
      EN         = ($urandom_range(0, 3) != 0);
      BR_VALID   = ($urandom_range(0, 3) == 0);
      BR_TARGET  = $urandom;
      JMP_VALID  = ($urandom_range(0, 5) == 0);
      JMP_TARGET = $urandom;
      EXC_VALID  = ($urandom_range(0, 19) == 0);
      HALT_REQ   = ($urandom_range(0, 24) == 0);
      RESUME     = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
